// File: rtl/egress_collector.sv
// egress_collector: tagged output queue behind an arbiter.
// Captures each granted word with its source tag, presents the queue head over
// valid/ready, gates the arbiter's requests by remaining queue credit, and
// flags multi-hot grants and grants that arrive with no space.
// Optional per-source delivered-word counters: define EGRESS_STATS_EN.
module egress_collector #(
  parameter int NUM_REQS = 2,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int SW       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQS-1:0]      reqs_in,
  output logic [NUM_REQS-1:0]      reqs_out,
  input  logic [NUM_REQS-1:0]      gnt,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [WIDTH-1:0]         out_data,
  output logic [SW-1:0]            out_src,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_multi,
  output logic                     err_ovf,
  input  logic                     stat_clr,
  output logic [NUM_REQS*16-1:0]   stat_counts
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = WIDTH + SW;

  logic [EW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;

  logic [SW-1:0]   src_tag;
  logic            tag_found;
  logic            push_req;
  logic            push_ok;
  logic            push_ovf;
  logic            pop;
  logic            multi_hot;
  logic [EW-1:0]   head;

  // Source tag is the index of the lowest set grant bit.
  always_comb begin
    src_tag   = '0;
    tag_found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (gnt[i] && !tag_found) begin
        src_tag   = SW'(i);
        tag_found = 1'b1;
      end
    end
  end

  // Push/pop qualification; a full queue still accepts a word when the head
  // leaves in the same cycle.
  always_comb begin
    push_req  = |gnt;
    multi_hot = |(gnt & (gnt - NUM_REQS'(1)));
    pop       = out_vld && out_rdy;
    push_ok   = push_req && ((cnt < CW'(DEPTH)) || pop);
    push_ovf  = push_req && !push_ok;
  end

  // Queue storage; contents need no reset since out_vld qualifies them.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {src_tag, data_in};
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky protocol-violation flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_multi <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      if (multi_hot) begin
        err_multi <= 1'b1;
      end
      if (push_ovf) begin
        err_ovf <= 1'b1;
      end
    end
  end

  // Head presentation straight from storage; zeroed while empty so the
  // outputs are defined after reset without resetting the storage array.
  always_comb begin
    head     = mem[rd_ptr];
    out_vld  = (cnt != '0);
    out_data = out_vld ? head[WIDTH-1:0] : '0;
    out_src  = out_vld ? head[EW-1:WIDTH] : '0;
    count    = cnt;
  end

  // Credit gate: one slot is kept back for a grant already in flight.
  always_comb begin
    reqs_out = (cnt <= CW'(DEPTH - 2)) ? reqs_in : '0;
  end

`ifdef EGRESS_STATS_EN
  logic [15:0] stat_q [NUM_REQS];

  // Per-source delivered-word counters; clear wins over an increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
        stat_q[i] <= '0;
      end
    end else if (stat_clr) begin
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
        if (pop && (out_src == SW'(i)) && (stat_q[i] != '1)) begin
          stat_q[i] <= stat_q[i] + 16'd1;
        end
      end
    end
  end

  // Flatten counters onto the output bus, source i at [16i+15:16i].
  always_comb begin
    stat_counts = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      stat_counts[i*16 +: 16] = stat_q[i];
    end
  end
`else
  logic unused_stat_clr;

  // Statistics disabled: bus tied off, clear input has no effect.
  always_comb begin
    stat_counts     = '0;
    unused_stat_clr = stat_clr;
  end
`endif

endmodule

// File: tb/tb_egress_collector.sv
// Directed self-checking bench for egress_collector (default parameters).
module tb_egress_collector;

  logic        clk;
  logic        rst;
  logic [1:0]  reqs_in;
  logic [1:0]  reqs_out;
  logic [1:0]  gnt;
  logic [7:0]  data_in;
  logic        out_vld;
  logic        out_rdy;
  logic [7:0]  out_data;
  logic [0:0]  out_src;
  logic [2:0]  count;
  logic        err_multi;
  logic        err_ovf;
  logic        stat_clr;
  logic [31:0] stat_counts;

  int total = 0;
  int bad   = 0;

  egress_collector #(
    .NUM_REQS(2),
    .WIDTH(8),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .reqs_in(reqs_in),
    .reqs_out(reqs_out),
    .gnt(gnt),
    .data_in(data_in),
    .out_vld(out_vld),
    .out_rdy(out_rdy),
    .out_data(out_data),
    .out_src(out_src),
    .count(count),
    .err_multi(err_multi),
    .err_ovf(err_ovf),
    .stat_clr(stat_clr),
    .stat_counts(stat_counts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    reqs_in  = '0;
    gnt      = '0;
    data_in  = '0;
    out_rdy  = 1'b0;
    stat_clr = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reqs_in = '0; gnt = '0; data_in = '0; out_rdy = 1'b0; stat_clr = 1'b0;
    step();
    step();
    total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", out_vld); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", out_data); end
    total++; if (out_src !== 1'b0) begin bad++; $display("FAIL reset_src got=%b want=0", out_src); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (err_multi !== 1'b0) begin bad++; $display("FAIL reset_err_multi got=%b want=0", err_multi); end
    total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL reset_err_ovf got=%b want=0", err_ovf); end
    total++; if (stat_counts !== 32'h0) begin bad++; $display("FAIL reset_stats got=%h want=0", stat_counts); end
    total++; if (reqs_out !== 2'b00) begin bad++; $display("FAIL reset_reqs got=%b want=00", reqs_out); end
    rst = 1'b0;
    step();
    reqs_in = 2'b11;
    #1;
    total++; if (reqs_out !== 2'b11) begin bad++; $display("FAIL idle_reqs got=%b want=11", reqs_out); end
    reqs_in = 2'b00;
  endtask

  task automatic test_single();
    do_reset();
    out_rdy = 1'b1;
    gnt = 2'b10; data_in = 8'hA5;
    step();
    gnt = 2'b00; data_in = 8'h00;
    total++; if (out_vld !== 1'b1) begin bad++; $display("FAIL single_vld got=%b want=1", out_vld); end
    total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", out_data); end
    total++; if (out_src !== 1'b1) begin bad++; $display("FAIL single_src got=%b want=1", out_src); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count1 got=%0d want=1", count); end
    step();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL single_count0 got=%0d want=0", count); end
    total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL single_vld0 got=%b want=0", out_vld); end
  endtask

  task automatic test_fill_overflow();
    logic [1:0] g  [5];
    logic [7:0] d  [5];
    logic [2:0] ec [5];
    logic [1:0] er [5];
    g[0] = 2'b01; d[0] = 8'h10; ec[0] = 3'd1; er[0] = 2'b11;
    g[1] = 2'b10; d[1] = 8'h11; ec[1] = 3'd2; er[1] = 2'b11;
    g[2] = 2'b01; d[2] = 8'h12; ec[2] = 3'd3; er[2] = 2'b00;
    g[3] = 2'b10; d[3] = 8'h13; ec[3] = 3'd4; er[3] = 2'b00;
    g[4] = 2'b01; d[4] = 8'hEE; ec[4] = 3'd4; er[4] = 2'b00;
    do_reset();
    reqs_in = 2'b11;
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      gnt = g[i]; data_in = d[i];
      step();
      gnt = 2'b00;
      #1;
      total++; if (count !== ec[i]) begin bad++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, count, ec[i]); end
      total++; if (reqs_out !== er[i]) begin bad++; $display("FAIL fill_reqs[%0d] got=%b want=%b", i, reqs_out, er[i]); end
      total++; if (err_ovf !== (i == 4)) begin bad++; $display("FAIL fill_ovf[%0d] got=%b want=%b", i, err_ovf, (i == 4)); end
    end
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_data !== d[i]) begin bad++; $display("FAIL drain_data[%0d] got=%h want=%h", i, out_data, d[i]); end
      total++; if (out_src !== g[i][1]) begin bad++; $display("FAIL drain_src[%0d] got=%b want=%b", i, out_src, g[i][1]); end
      step();
    end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL drain_count got=%0d want=0", count); end
    total++; if (err_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", err_ovf); end
    reqs_in = 2'b00;
  endtask

  task automatic test_full_simul();
    logic [7:0] exp_d [4];
    logic       exp_s [4];
    exp_d[0] = 8'h21; exp_s[0] = 1'b1;
    exp_d[1] = 8'h22; exp_s[1] = 1'b0;
    exp_d[2] = 8'h23; exp_s[2] = 1'b1;
    exp_d[3] = 8'h24; exp_s[3] = 1'b0;
    do_reset();
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      data_in = 8'h20 + 8'(i);
      step();
    end
    gnt = 2'b01; data_in = 8'h24; out_rdy = 1'b1;
    step();
    gnt = 2'b00;
    total++; if (count !== 3'd4) begin bad++; $display("FAIL simul_count got=%0d want=4", count); end
    total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL simul_ovf got=%b want=0", err_ovf); end
    for (int i = 0; i < 4; i++) begin
      total++; if (out_data !== exp_d[i]) begin bad++; $display("FAIL simul_data[%0d] got=%h want=%h", i, out_data, exp_d[i]); end
      total++; if (out_src !== exp_s[i]) begin bad++; $display("FAIL simul_src[%0d] got=%b want=%b", i, out_src, exp_s[i]); end
      step();
    end
    total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL simul_empty got=%b want=0", out_vld); end
  endtask

  task automatic test_multi();
    do_reset();
    out_rdy = 1'b0;
    gnt = 2'b11; data_in = 8'h3C;
    step();
    gnt = 2'b00; data_in = 8'h00;
    total++; if (err_multi !== 1'b1) begin bad++; $display("FAIL multi_err got=%b want=1", err_multi); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL multi_count got=%0d want=1", count); end
    total++; if (out_src !== 1'b0) begin bad++; $display("FAIL multi_src got=%b want=0", out_src); end
    total++; if (out_data !== 8'h3C) begin bad++; $display("FAIL multi_data got=%h want=3c", out_data); end
    step();
    total++; if (out_data !== 8'h3C) begin bad++; $display("FAIL stall_hold got=%h want=3c", out_data); end
    total++; if (err_multi !== 1'b1) begin bad++; $display("FAIL multi_sticky got=%b want=1", err_multi); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (err_multi !== 1'b0) begin bad++; $display("FAIL async_err_multi got=%b want=0", err_multi); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL async_count got=%0d want=0", count); end
    total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL async_vld got=%b want=0", out_vld); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_stats();
    logic [1:0] g [4];
    g[0] = 2'b01; g[1] = 2'b01; g[2] = 2'b10; g[3] = 2'b01;
    do_reset();
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      gnt = g[i]; data_in = 8'h40 + 8'(i);
      step();
    end
    gnt = 2'b00;
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) step();
    out_rdy = 1'b0;
`ifdef EGRESS_STATS_EN
    total++; if (stat_counts !== {16'd1, 16'd3}) begin bad++; $display("FAIL stats_count got=%h want=00010003", stat_counts); end
`else
    total++; if (stat_counts !== 32'h0) begin bad++; $display("FAIL stats_tied got=%h want=0", stat_counts); end
`endif
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    total++; if (stat_counts !== 32'h0) begin bad++; $display("FAIL stats_clr got=%h want=0", stat_counts); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_simul();
    test_multi();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule

// File: doc/egress_collector.md
# egress_collector

Downstream stage for one `arbitrated_fifos` instance. Captures each granted word (`gnt`/`data_out`) into a small tagged output queue and presents it to the consumer over a valid/ready handshake. Gates the arbiter's request vector by queue credit so no granted word is ever dropped. Flags protocol violations: multi-hot grant, grant into a full queue.

## Interface
Parameters:
- NUM_REQS, 2, number of arbitrated sources; width of `gnt`/`reqs_*`
- WIDTH, 8, data word width
- DEPTH, 4, output queue entries; power of two, ≥2
- SW, $clog2(NUM_REQS) (min 1), source tag width; derived, do not override

Ports (clock and reset: one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- reqs_in  in  NUM_REQS  raw request vector from the request policy
- reqs_out  out  NUM_REQS  credit-gated requests driven to the arbiter `reqs`
- gnt  in  NUM_REQS  grant/pop vector from the arbiter; expected one-hot or zero
- data_in  in  WIDTH  arbiter `data_out`, valid in the same cycle as `gnt`
- out_vld  out  1  queue head valid
- out_rdy  in  1  consumer ready
- out_data  out  WIDTH  queue head data
- out_src  out  SW  queue head source index
- count  out  $clog2(DEPTH)+1  current occupancy
- err_multi  out  1  sticky: multi-hot `gnt` seen
- err_ovf  out  1  sticky: `gnt` while no space
- stat_clr  in  1  synchronous clear of statistics
- stat_counts  out  NUM_REQS*16  per-source delivered-word counters, source i at [16i+15:16i]

## Operation
- Queue: circular buffer, DEPTH×(WIDTH+SW), write pointer, read pointer, occupancy counter.
- Push when `|gnt`: write {tag, data_in}; tag = index of lowest set bit of `gnt`.
- Pop when out_vld && out_rdy.
- Credit: reqs_out = reqs_in when count ≤ DEPTH-2, else all zero. One slot reserved for a grant issued on the last cycle requests were allowed.
- Push accepted if count < DEPTH, or count == DEPTH with a pop in the same cycle. Otherwise the word is discarded, pointers and count unchanged, err_ovf set.
- Simultaneous push and pop: count unchanged, both pointers advance.
- popcount(gnt) > 1: err_multi set; exactly one word pushed, tagged with the lowest index.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- err_multi and err_ovf clear only on rst.
- out_data/out_src/out_vld are driven from the head entry, without an extra output register. out_data is held stable while out_vld && !out_rdy.

## Timing
- Reset values: reqs_out=0, out_vld=0, out_data=0, out_src=0, count=0, err_multi=0, err_ovf=0, stat_counts=0. Queue storage contents are don't-care.
- Reset asserted mid-operation: queue empties immediately (asynchronous); in-flight words are lost.
- reqs_out is combinational from reqs_in and registered count.
- Push latency: a word granted in cycle N gives out_vld=1 in cycle N+1 if the queue was empty.
- Empty queue: out_vld=0 and out_rdy is ignored. A push into an empty queue is not bypassed to the output in the same cycle.
- Full queue (count=DEPTH): out_vld=1, reqs_out=0.

## Configuration
- EGRESS_STATS_EN defined:
  - stat_counts[i] increments by 1 on each pop whose out_src==i.
  - Counters saturate at 16'hFFFF.
  - stat_clr zeroes all counters next edge; clear wins over a same-cycle increment.
- EGRESS_STATS_EN undefined:
  - Counters not instantiated; stat_counts tied to 0.
  - stat_clr ignored.
  - Ports remain present.

## Test plan
- Reset, then idle → all outputs 0; reqs_in=2'b11 gives reqs_out=2'b11.
- gnt=2'b10 with data_in=8'hA5 at cycle N, out_rdy=1 → cycle N+1: out_vld=1, out_data=A5, out_src=1; cycle N+2: count=0.
- DEPTH=4, out_rdy=0, four single grants → reqs_out drops to 0 once count=3; fourth grant accepted; a fifth grant sets err_ovf and leaves count=4. Then out_rdy=1 → words drain in order.
- Full queue, same-cycle gnt and pop → count stays 4, the new word lands at the tail, err_ovf stays 0.
- gnt=2'b11, data 8'h3C → err_multi=1, one entry with out_src=0; a later rst clears err_multi.
- EGRESS_STATS_EN: pop 3 words from source 0 and 1 from source 1 → stat_counts={16'd1,16'd3}. Pulse stat_clr → all zero.
